// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4
//   Four-requester round-robin arbiter feeding one registered output stage.
//   Each cycle the requester closest to the priority pointer (scanning
//   ptr, ptr+1, ptr+2, ptr+3 mod 4) wins. Its data is captured into a
//   single-entry valid/ready output stage. The pointer advances past the
//   winner only on an actual transfer.
//
// Ports
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_valid  per-requester valid, bit k belongs to requester k
//   i_data0..i_data3  requester data
//   o_ready  per-requester ready, one-hot or zero
//   o_valid  output stage holds a beat
//   o_data   registered winning data
//   o_sel    index of the requester whose beat is in o_data
//   i_ready  downstream accepts o_data
module rr_mux_arbiter_4 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [3:0]       i_valid,
   input  logic [WIDTH-1:0] i_data0,
   input  logic [WIDTH-1:0] i_data1,
   input  logic [WIDTH-1:0] i_data2,
   input  logic [WIDTH-1:0] i_data3,
   output logic [3:0]       o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_sel,
   input  logic             i_ready
);

   logic [1:0]       ptr;
   logic [1:0]       grant_idx;
   logic             grant_vld;
   logic [1:0]       scan;
   logic             load_ok;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;

   // Stage can take a new beat when empty or when its beat leaves now.
   assign load_ok = !o_valid || i_ready;

   // First valid requester at or after ptr, wrapping modulo 4.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = ptr;
      scan      = ptr;
      for (int unsigned k = 0; k < 4; k++) begin
         scan = ptr + 2'(k);
         if (!grant_vld && i_valid[scan]) begin
            grant_vld = 1'b1;
            grant_idx = scan;
         end
      end
   end

   assign xfer = grant_vld && load_ok && !i_rst;

   always_comb begin
      o_ready = '0;
      if (xfer) begin
         o_ready[grant_idx] = 1'b1;
      end
   end

   // Data select feeds only the output register, never an output directly.
   always_comb begin
      sel_data = '0;
      case (grant_idx)
         2'd0:    sel_data = i_data0;
         2'd1:    sel_data = i_data1;
         2'd2:    sel_data = i_data2;
         default: sel_data = i_data3;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_sel   <= '0;
         ptr     <= '0;
      end else if (xfer) begin
         // Load takes precedence over drain so a simultaneous drain and
         // load keeps o_valid high at full throughput.
         o_valid <= 1'b1;
         o_data  <= sel_data;
         o_sel   <= grant_idx;
         ptr     <= grant_idx + 2'd1;
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
module tb_rr_mux_arbiter_4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  valid;
   logic [31:0] d [4];
   logic [3:0]  o_ready;
   logic        o_valid;
   logic [31:0] o_data;
   logic [1:0]  o_sel;
   logic        ready;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit          m_valid;
   logic [31:0] m_data;
   int          m_sel;
   int          m_ptr;

   always #5 clk = ~clk;

   rr_mux_arbiter_4 #(.WIDTH(32)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (valid),
      .i_data0 (d[0]),
      .i_data1 (d[1]),
      .i_data2 (d[2]),
      .i_data3 (d[3]),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_data  (o_data),
      .o_sel   (o_sel),
      .i_ready (ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner by the round-robin rule: first valid index counting up from ptr.
   function automatic int winner();
      for (int k = 0; k < 4; k++) begin
         if (valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready();
      logic [3:0] r;
      int w;
      r = 4'b0000;
      w = winner();
      if (!rst && w >= 0 && (!m_valid || ready)) r[w] = 1'b1;
      return r;
   endfunction

   // One clock: check ready mid-cycle, advance model at the edge, check outputs.
   task automatic cycle();
      int w;
      @(negedge clk);
      chk("o_ready", 64'(o_ready), 64'(exp_ready()));
      @(posedge clk);
      w = winner();
      if (rst) begin
         m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
      end else if (w >= 0 && (!m_valid || ready)) begin
         m_valid = 1; m_data = d[w]; m_sel = w; m_ptr = (w + 1) % 4;
      end else if (m_valid && ready) begin
         m_valid = 0;
      end
      #1;
      chk("o_valid", 64'(o_valid), 64'(m_valid));
      if (m_valid || rst) begin
         chk("o_data", 64'(o_data), 64'(m_data));
         chk("o_sel", 64'(o_sel), 64'(m_sel));
      end
   endtask

   initial begin
      int seq [8];
      rst = 1'b1; valid = '0; ready = 1'b0;
      for (int k = 0; k < 4; k++) d[k] = '0;
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
      cycle();
      cycle();
      chk("rst_o_valid", 64'(o_valid), 64'd0);
      chk("rst_o_data", 64'(o_data), 64'd0);
      chk("rst_o_sel", 64'(o_sel), 64'd0);
      chk("rst_o_ready", 64'(o_ready), 64'd0);

      // Single requester 2
      rst = 1'b0; valid = 4'b0100; d[2] = 32'hA5A5_0002; ready = 1'b1;
      #1 chk("solo_ready", 64'(o_ready), 64'b0100);
      cycle();
      chk("solo_valid", 64'(o_valid), 64'd1);
      chk("solo_data", 64'(o_data), 64'hA5A5_0002);
      chk("solo_sel", 64'(o_sel), 64'd2);

      // Drain without refill
      valid = 4'b0000;
      cycle();
      chk("drain_valid", 64'(o_valid), 64'd0);
      chk("drain_hold", 64'(o_data), 64'hA5A5_0002);

      // All valid: pointer left at 3 gives requester 3 first
      valid = 4'b1111;
      for (int k = 0; k < 4; k++) d[k] = 32'(k + 1);
      cycle();
      chk("ptr3_sel", 64'(o_sel), 64'd3);

      // Fairness rotation
      seq = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rot_sel", 64'(o_sel), 64'(seq[i]));
         chk("rot_data", 64'(o_data), 64'(seq[i] + 1));
         chk("rot_valid", 64'(o_valid), 64'd1);
      end

      // Backpressure: load 0 then 1, stall 3 cycles
      cycle();
      cycle();
      chk("bp_sel1", 64'(o_sel), 64'd1);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_ready", 64'(o_ready), 64'd0);
         chk("bp_sel", 64'(o_sel), 64'd1);
         chk("bp_data", 64'(o_data), 64'd2);
         chk("bp_valid", 64'(o_valid), 64'd1);
      end
      ready = 1'b1;
      #1 chk("bp_release_ready", 64'(o_ready), 64'b0100);
      cycle();
      chk("bp_release_sel", 64'(o_sel), 64'd2);

      // Sparse: bring ptr to 1, then only 0 and 3 valid
      valid = 4'b0001;
      cycle();
      valid = 4'b1001;
      seq = '{3, 0, 3, 0, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("sparse_sel", 64'(o_sel), 64'(seq[i]));
      end

      // Reset mid-operation with o_valid=1 and ptr=2
      valid = 4'b0010; d[1] = 32'hDEAD_0001;
      cycle();
      chk("pre_rst_valid", 64'(o_valid), 64'd1);
      ready = 1'b0; rst = 1'b1;
      cycle();
      chk("mid_rst_valid", 64'(o_valid), 64'd0);
      chk("mid_rst_data", 64'(o_data), 64'd0);
      chk("mid_rst_sel", 64'(o_sel), 64'd0);
      rst = 1'b0; ready = 1'b1; valid = 4'b1111;
      cycle();
      chk("post_rst_sel", 64'(o_sel), 64'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         valid = 4'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         rst   = ($urandom_range(0, 40) == 0);
         for (int k = 0; k < 4; k++) d[k] = $urandom;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one WIDTH-bit output channel between four valid/ready sources.
- Selects a winner each cycle, steers its data through a 4:1 select, and registers the result into a single-entry output stage with valid/ready handshake.
- Sits in front of any shared downstream consumer (bus, FIFO, ALU port) that accepts one beat per cycle.

Parameters:
- WIDTH, 32, data width of each input channel and of the output.

Ports:
- i_clk  input  1  clock; the block's only clock.
- i_rst  input  1  reset; synchronous to i_clk, active-high.
- i_valid  input  4  per-requester valid; bit k belongs to requester k.
- i_data0  input  WIDTH  requester 0 data.
- i_data1  input  WIDTH  requester 1 data.
- i_data2  input  WIDTH  requester 2 data.
- i_data3  input  WIDTH  requester 3 data.
- o_ready  output  4  per-requester ready; one-hot or zero.
- o_valid  output  1  output stage holds a beat.
- o_data  output  WIDTH  registered winning data.
- o_sel  output  2  index of the requester whose beat is in o_data.
- i_ready  input  1  downstream accepts o_data.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - o_valid=0, o_data=0, o_sel=0.
  - Priority pointer ptr=0, so requester 0 has highest priority first.
  - o_ready=0 while i_rst is high.
- load_ok = !o_valid || i_ready. The stage is empty, or its beat leaves this cycle.
- Arbitration is combinational, evaluated every cycle:
  - Scan requesters in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first k with i_valid[k]=1 is the winner g.
  - o_ready[g] = load_ok. All other o_ready bits are 0.
  - If no i_valid bit is set, o_ready=0.
- Transfer from requester g occurs when i_valid[g] && o_ready[g]. At that edge:
  - o_data <= i_data{g}, o_sel <= g, o_valid <= 1.
  - ptr <= (g+1) mod 4, with 2-bit wrap (3 -> 0).
- Output drain:
  - If o_valid && i_ready and no new transfer occurs, o_valid <= 0.
  - o_data and o_sel hold their last values.
- Simultaneous drain and load (o_valid=1, i_ready=1, winner present):
  - The new beat replaces the old one in the same cycle.
  - o_valid stays 1, giving full throughput of 1 beat/cycle.
- Backpressure (o_valid=1, i_ready=0):
  - load_ok=0, so o_ready=0.
  - o_data, o_sel, o_valid and ptr are frozen.
- Latency: 1 cycle from accepted input to o_valid.
- ptr changes only on a transfer. An idle cycle or a stalled cycle never rotates priority.
- Fairness: with all four requesters continuously valid and i_ready=1, grants cycle 0,1,2,3,0,... Worst-case wait for a held request is 3 transfers.
- Sources must hold i_valid and data until accepted. The arbiter may still re-pick a different winner next cycle if the pointer has not moved, because priority is recomputed every cycle.
- Reset mid-operation: any beat in the output stage is discarded (o_valid=0), and ptr returns to 0.
- o_data is fully registered. o_ready depends combinationally on i_valid, i_ready and state; there is no combinational path from i_data to any output.

Test Plan:
- Reset, then requester 2 only valid with i_data2=32'hA5A5_0002 and i_ready=1 -> o_ready=4'b0100. The next cycle shows o_valid=1, o_data=32'hA5A5_0002, o_sel=2. ptr=3 afterwards.
- All four i_valid=1 continuously, i_dataK=K+1, i_ready=1, for 8 cycles -> o_sel sequence 0,1,2,3,0,1,2,3 and o_data 1,2,3,4,1,2,3,4, with o_valid=1 every cycle after the first.
- Backpressure: beat from requester 1 loaded, then i_ready=0 for 3 cycles with all i_valid=1 -> o_ready=0, and o_data/o_sel/o_valid stay unchanged. Raising i_ready gives the next grant to requester 2 in the same cycle.
- Sparse requests: only requesters 0 and 3 valid, ptr=1 -> requester 3 wins first, then 0, then 3, alternating.
- Drain without refill: one beat loaded, all i_valid=0, i_ready=1 -> o_valid falls to 0 the next cycle, and o_data holds its value.
- Reset asserted while o_valid=1 and ptr=2 -> the next cycle shows o_valid=0, o_data=0, o_sel=0, and the first grant after reset goes to requester 0 when all are valid.
